// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width codes, response error codes and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  // Classify a request; illegal width beats misalignment beats range.
  function automatic logic [1:0] check_req(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo,
                                           input logic       out_of_range);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (!is_store && ((f3 == F3_BU) || (f3 == F3_HU)));
    if (!legal)
      return ERR_ILLEGAL;
    else if (((f3[1:0] == 2'b01) && addr_lo[0]) ||
             ((f3[1:0] == 2'b10) && (addr_lo != 2'b00)))
      return ERR_MISALIGN;
    else if (out_of_range)
      return ERR_RANGE;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword
// of a memory word for loads, and merges store data into a word for SB/SH.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = mem_word[{addr_lo, 3'b000} +: 8];
  assign half_val = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

  // Width selection and sign/zero extension of the extracted lane.
  always_comb begin
    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'd0, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'd0, half_val};
      default: load_data = mem_word;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_sel;
    logic [7:0] lane_src;
    assign lane_sel = (funct3[1:0] == 2'b00) ? (addr_lo == LANE) :
                      (funct3[1:0] == 2'b01) ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign lane_src = (funct3[1:0] == 2'b10) ? store_data[8*gi +: 8] :
                      ((funct3[1:0] == 2'b01) && LANE[0]) ? store_data[15:8] :
                      store_data[7:0];
    assign merged_word[8*gi +: 8] = lane_sel ? lane_src : mem_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, combinational-read data
// memory. Sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        is_store_reg;
  logic [31:0] wr_word_reg;
  logic [31:0] resp_rdata_reg;
  logic [1:0]  resp_err_reg;

  logic        out_of_range;
  logic [1:0]  req_err;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign out_of_range = (req_addr >> ADDR_BITS) != 32'd0;
  assign req_err      = check_req(req_is_store, req_funct3, req_addr[1:0], out_of_range);
  assign accept       = req_valid && (state_reg == IDLE);
  assign resp_rdata   = resp_rdata_reg;
  assign resp_err     = resp_err_reg;

  lsu_lane_align u_lane_align (
    .mem_word    (mem_read_data),
    .addr_lo     (addr_reg[1:0]),
    .funct3      (funct3_reg),
    .store_data  (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and memory/handshake outputs, all decoded from the state.
  always_comb begin
    state_next     = state_reg;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 32'd0;
    mem_write_data = 32'd0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err != ERR_OK)                          state_next = RESP;
          else if (!req_is_store || (req_funct3 != F3_W)) state_next = RD;
          else                                            state_next = WR;
        end
      end
      RD: begin
        mem_read   = 1'b1;
        mem_addr   = {addr_reg[31:2], 2'b00};
        state_next = is_store_reg ? WR : RESP;
      end
      WR: begin
        mem_write      = 1'b1;
        mem_addr       = {addr_reg[31:2], 2'b00};
        mem_write_data = wr_word_reg;
        state_next     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, RMW merge capture and response registers; the response
  // registers only change on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      funct3_reg     <= 3'd0;
      is_store_reg   <= 1'b0;
      wr_word_reg    <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= ERR_OK;
    end else begin
      if (accept) begin
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        funct3_reg   <= req_funct3;
        is_store_reg <= req_is_store;
        wr_word_reg  <= req_wdata;
        if (req_err != ERR_OK) begin
          resp_rdata_reg <= 32'd0;
          resp_err_reg   <= req_err;
        end
      end
      if (state_reg == RD) begin
        if (is_store_reg) begin
          wr_word_reg <= merged_word;
        end else begin
          resp_rdata_reg <= load_data;
          resp_err_reg   <= ERR_OK;
        end
      end
      if (state_reg == WR) begin
        resp_rdata_reg <= 32'd0;
        resp_err_reg   <= ERR_OK;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory model, a response
// scoreboard with cycle-accurate latency, a vector table and corner sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_BITS(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Data memory model: 4096 words, combinational read, write on clock edge.
  logic [31:0] mem [0:4095];
  assign mem_read_data = mem[mem_addr[13:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[13:2]] <= mem_write_data;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_wdata = 32'd0;

  // Monitor: count memory activity, pop and compare each response.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin wr_cnt++; last_wdata = mem_write_data; end
      if (mem_read && mem_write) both_cnt++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got resp_valid=1 required no response");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("[TB] resp at cycle %0d rdata=0x%08h err=%0d", cyc, resp_rdata, resp_err);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {30'd0, resp_err}, {30'd0, e.err});
          chk("resp_cycle", cyc, e.at);
        end
      end
    end
  end

  // Drive a request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic [1:0] ee,
                       input int lat, output int c);
    int guard = 0;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got req_ready=0 required 1");
    end
    c = cyc;
    sb_q.push_back('{rdata: er, err: ee, at: cyc + lat});
    @(negedge clk);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 30) begin @(negedge clk); guard++; end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;
  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    int c1, c2;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[32'h40 >> 2] = 32'h8899AABB;
    mem[32'h80 >> 2] = 32'h11223344;

    vecs[0]  = '{1'b0, 3'b000, 32'h41,   32'h0,        32'hFFFFFFAA, 2'd0, 2, 1, 0};
    vecs[1]  = '{1'b0, 3'b100, 32'h41,   32'h0,        32'h000000AA, 2'd0, 2, 1, 0};
    vecs[2]  = '{1'b0, 3'b001, 32'h42,   32'h0,        32'hFFFF8899, 2'd0, 2, 1, 0};
    vecs[3]  = '{1'b0, 3'b101, 32'h40,   32'h0,        32'h0000AABB, 2'd0, 2, 1, 0};
    vecs[4]  = '{1'b0, 3'b010, 32'h40,   32'h0,        32'h8899AABB, 2'd0, 2, 1, 0};
    vecs[5]  = '{1'b0, 3'b000, 32'h43,   32'h0,        32'hFFFFFF88, 2'd0, 2, 1, 0};
    vecs[6]  = '{1'b0, 3'b100, 32'h40,   32'h0,        32'h000000BB, 2'd0, 2, 1, 0};
    vecs[7]  = '{1'b1, 3'b000, 32'h81,   32'h12345655, 32'h0,        2'd0, 3, 1, 1};
    vecs[8]  = '{1'b0, 3'b010, 32'h80,   32'h0,        32'hBEEF5544, 2'd0, 2, 1, 0};
    vecs[9]  = '{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        2'd1, 1, 0, 0};
    vecs[10] = '{1'b0, 3'b011, 32'h0,    32'h0,        32'h0,        2'd2, 1, 0, 0};
    vecs[11] = '{1'b0, 3'b010, 32'h4000, 32'h0,        32'h0,        2'd3, 1, 0, 0};
    vecs[12] = '{1'b1, 3'b100, 32'h1,    32'h0,        32'h0,        2'd2, 1, 0, 0};
    vecs[13] = '{1'b0, 3'b001, 32'h4001, 32'h0,        32'h0,        2'd1, 1, 0, 0};
    vecs[14] = '{1'b1, 3'b010, 32'h4000, 32'h1,        32'h0,        2'd3, 1, 0, 0};
    vecs[15] = '{1'b1, 3'b001, 32'h83,   32'h1,        32'h0,        2'd1, 1, 0, 0};
    vecs[16] = '{1'b0, 3'b001, 32'h3FFE, 32'h0,        32'h0,        2'd0, 2, 1, 0};
    vecs[17] = '{1'b1, 3'b000, 32'h3FFF, 32'h000000A5, 32'h0,        2'd0, 3, 1, 1};
    vecs[18] = '{1'b0, 3'b000, 32'h3FFF, 32'h0,        32'hFFFFFFA5, 2'd0, 2, 1, 0};
    vecs[19] = '{1'b0, 3'b101, 32'h3FFE, 32'h0,        32'h0000A500, 2'd0, 2, 1, 0};

    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SH into word 0x80 by read-modify-write.
    rd_cnt = 0; wr_cnt = 0;
    issue(1'b1, 3'b001, 32'h82, 32'h0000BEEF, 32'h0, 2'd0, 3, c1);
    req_valid = 1'b0;
    wait_done();
    $display("[TB] SH 0x82 write data 0x%08h", last_wdata);
    chk("sh_write_data", last_wdata, 32'hBEEF3344);
    chk("sh_mem_word", mem[32'h80 >> 2], 32'hBEEF3344);
    chk("sh_rd_cnt", rd_cnt, 1);
    chk("sh_wr_cnt", wr_cnt, 1);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      rd_cnt = 0; wr_cnt = 0;
      $display("[TB] vec %0d st=%0d f3=%0d addr=0x%08h wdata=0x%08h", i, vecs[i].st,
               vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      issue(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
            vecs[i].err, vecs[i].lat, c1);
      req_valid = 1'b0;
      wait_done();
      chk($sformatf("vec%0d_rd_cnt", i), rd_cnt, vecs[i].nrd);
      chk($sformatf("vec%0d_wr_cnt", i), wr_cnt, vecs[i].nwr);
    end
    chk("sb_mem_word", mem[32'h80 >> 2], 32'hBEEF5544);

    // Reset in the RD cycle of an SB: no write may reach memory.
    rd_cnt = 0; wr_cnt = 0;
    issue(1'b1, 3'b000, 32'h40, 32'h00000077, 32'h0, 2'd0, 3, c1);
    req_valid = 1'b0;
    chk("rmw_in_rd", {31'd0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("[TB] reset during RD: req_ready=%0d mem_read=%0d mem_write=%0d", req_ready, mem_read, mem_write);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_wr_cnt", wr_cnt, 0);
    chk("abort_mem_word", mem[32'h40 >> 2], 32'h8899AABB);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 2'd0, 2, c1);
    req_valid = 1'b0;
    wait_done();

    // Back-to-back SW then LW with req_valid held high.
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 2'd0, 2, c1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 2'd0, 2, c2);
    req_valid = 1'b0;
    wait_done();
    $display("[TB] back-to-back accepts at %0d and %0d", c1, c2);
    chk("b2b_accept_gap", c2 - c1, 3);

    chk("rd_wr_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14: byte-address bits decoded by data memory; req_addr[31:ADDR_BITS] nonzero is out-of-range.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port req_is_store, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: load result.
REQ-012 SHALL have port resp_err, output, 2: 00 ok, 01 misaligned, 10 illegal funct3, 11 out-of-range.
REQ-013 SHALL have ports mem_addr (output, 32), mem_write_data (output, 32), mem_read (output, 1), mem_write (output, 1), mem_read_data (input, 32): word-wide data-memory port (combinational read, write on clk edge).

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready, registering all req_* fields.
REQ-016 SHALL check on acceptance, priority illegal > misaligned > out-of-range; halfword addr[0]=1 or word addr[1:0]!=0 is misaligned; error requests go IDLE->RESP with no memory access, resp_rdata 0.
REQ-017 SHALL run loads IDLE->RD->RESP: mem_read=1 in RD, extracted lane captured at end of RD; resp_valid in cycle N+2 after acceptance edge N.
REQ-018 SHALL extract byte lane addr[1:0] / halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-019 SHALL run SW IDLE->WR->RESP with mem_write=1 and mem_write_data=req_wdata in WR; resp_valid in cycle N+2.
REQ-020 SHALL run SB/SH as read-modify-write IDLE->RD->WR->RESP: RD reads the word, the selected lane is replaced by req_wdata[7:0]/[15:0], other lanes kept; WR writes the merged word; resp_valid in cycle N+3.
REQ-021 SHALL drive mem_addr = {addr[31:2],2'b00} in RD/WR, 0 otherwise; mem_read and mem_write never both 1; both 0 outside RD/WR.
REQ-022 SHALL pulse resp_valid for exactly the RESP cycle, then return to IDLE; no back-pressure on responses.
REQ-023 SHALL hold resp_rdata and resp_err stable from RESP until the next RESP; stores report resp_rdata 0.
REQ-024 SHALL ignore req_valid while not in IDLE; a new request MAY be accepted the cycle after RESP.

Reset
REQ-025 SHALL on rst asynchronously force state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 00, mem_read 0, mem_write 0, mem_addr 0, mem_write_data 0.
REQ-026 SHALL abandon any in-flight request on rst; a write whose WR clock edge did not occur before rst SHALL NOT reach memory.

Structure
REQ-027 SHALL place FSM state encoding, funct3 codes and resp_err codes in shared package lsu_pkg.
REQ-028 SHALL factor lane extract/merge/extend into combinational sub-module lsu_lane_align.

Verification
REQ-029 SHALL test: mem word 0x8899AABB at 0x40, LB 0x41 -> resp_rdata 0xFFFFFFAA at N+2; LBU 0x41 -> 0x000000AA.
REQ-030 SHALL test: mem 0x11223344 at 0x80, SH 0x82 data 0x0000BEEF -> write 0xBEEF3344 in WR, resp_valid at N+3, resp_err 00.
REQ-031 SHALL test: LW 0x102 -> resp_err 01 at N+1, mem_read/mem_write never asserted.
REQ-032 SHALL test: load funct3 011 at 0x0 -> resp_err 10; LW 0x4000 with ADDR_BITS 14 -> resp_err 11.
REQ-033 SHALL test: rst asserted during RD of SB -> mem_write never asserted, state IDLE, req_ready 1 same cycle.
REQ-034 SHALL test: req_valid held high back-to-back SW,LW same address 0x20 data 0xCAFEF00D -> LW returns 0xCAFEF00D, second accepted cycle after first RESP.
